// File: rtl/mul_pipe_if.sv
// Issue/result bundle for the pipelined multiplier.
// The issuer drives the operation fields. The multiplier drives the result fields.
interface mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             valid_i;
    logic [2:0]       funct3_i;
    logic [WIDTH-1:0] op1_data_i;
    logic [WIDTH-1:0] op2_data_i;
    logic [RD_W-1:0]  rd_i;
    logic             ctrl_reg_write_i;
    logic             flush_i;

    logic             valid_result_o;
    logic [WIDTH-1:0] result_o;
    logic [RD_W-1:0]  rd_o;
    logic             ctrl_reg_write_o;
    logic             op_ending_o;
    logic             busy_o;
    logic             unsupported_o;

    // Valid/ready semantics: there is no ready. An issue is taken on every edge
    // where valid_i=1, funct3_i[2]=0 and flush_i=0. A result is presented for
    // exactly one cycle while valid_result_o=1, and the consumer must take it.
    modport master (
        output valid_i, funct3_i, op1_data_i, op2_data_i, rd_i, ctrl_reg_write_i, flush_i,
        input  valid_result_o, result_o, rd_o, ctrl_reg_write_o, op_ending_o, busy_o,
               unsupported_o
    );

    modport slave (
        input  valid_i, funct3_i, op1_data_i, op2_data_i, rd_i, ctrl_reg_write_i, flush_i,
        output valid_result_o, result_o, rd_o, ctrl_reg_write_o, op_ending_o, busy_o,
               unsupported_o
    );
endinterface

// File: rtl/mul_pipe.sv
// Fully pipelined RV32/64 M-extension multiplier (MUL/MULH/MULHSU/MULHU).
// Slot 0 holds extended operands, slot 1 the selected product, later slots carry it to the output.
module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 5,
    parameter int RD_W   = 5
) (
    input logic      clk,
    input logic      reset_n,
    mul_pipe_if.slave bus
);
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] wr_q, wr_d;
    logic [RD_W-1:0]   rd_q [STAGES];
    logic [RD_W-1:0]   rd_d [STAGES];
    logic [WIDTH-1:0]  res_q [1:LAST];
    logic [WIDTH-1:0]  res_d [1:LAST];
    logic [WIDTH:0]    a_q, a_d;
    logic [WIDTH:0]    b_q, b_d;
    logic              hi_q, hi_d;
    logic              unsup_q, unsup_d;

    logic              accept;
    logic              a_signed;
    logic              b_signed;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        accept   = bus.valid_i & ~bus.funct3_i[2] & ~bus.flush_i;
        unsup_d  = bus.valid_i &  bus.funct3_i[2] & ~bus.flush_i;
        // MULHU (2'b11) is the only op with unsigned rs1; rs2 is signed only for MUL/MULH.
        a_signed = (bus.funct3_i[1:0] != 2'b11);
        b_signed = ~bus.funct3_i[1];
        a_d      = {a_signed & bus.op1_data_i[WIDTH-1], bus.op1_data_i};
        b_d      = {b_signed & bus.op2_data_i[WIDTH-1], bus.op2_data_i};
        hi_d     = (bus.funct3_i[1:0] != 2'b00);

        vld_d    = {vld_q[STAGES-2:0], accept};
        if (bus.flush_i) begin
            vld_d = '0;
        end
        wr_d     = {wr_q[STAGES-2:0], bus.ctrl_reg_write_i};
        rd_d[0]  = bus.rd_i;
        for (int k = 1; k < STAGES; k++) begin
            rd_d[k] = rd_q[k-1];
        end

        // Modulo-2^(2W) product of the (W+1)-bit operands equals the truncated signed product.
        prod     = {{(WIDTH-1){a_q[WIDTH]}}, a_q} * {{(WIDTH-1){b_q[WIDTH]}}, b_q};
        res_d[1] = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        for (int k = 2; k < STAGES; k++) begin
            res_d[k] = res_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q   <= '0;
            wr_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= 1'b0;
            unsup_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= '0;
            end
            for (int k = 1; k < STAGES; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            unsup_q <= unsup_d;
            for (int k = 0; k < STAGES; k++) begin
                rd_q[k] <= rd_d[k];
            end
            for (int k = 1; k < STAGES; k++) begin
                res_q[k] <= res_d[k];
            end
        end
    end

    assign bus.valid_result_o   = vld_q[LAST];
    assign bus.result_o         = res_q[LAST];
    assign bus.rd_o             = rd_q[LAST];
    assign bus.ctrl_reg_write_o = vld_q[LAST] & wr_q[LAST];
    assign bus.op_ending_o      = vld_q[STAGES-2] & ~bus.flush_i;
    assign bus.busy_o           = |vld_q;
    assign bus.unsupported_o    = unsup_q;
endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe: a 32-bit/5-stage instance and a 64-bit/2-stage instance.
module tb_mul_pipe;
    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mul_pipe_if #(.WIDTH(32), .RD_W(5)) ifa ();
    mul_pipe_if #(.WIDTH(64), .RD_W(5)) ifb ();

    mul_pipe #(.WIDTH(32), .STAGES(5), .RD_W(5)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa)
    );
    mul_pipe #(.WIDTH(64), .STAGES(2), .RD_W(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue_a(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd, input logic wr);
        ifa.valid_i          = 1'b1;
        ifa.funct3_i         = f3;
        ifa.op1_data_i       = a;
        ifa.op2_data_i       = b;
        ifa.rd_i             = rd;
        ifa.ctrl_reg_write_i = wr;
    endtask

    task automatic issue_b(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd, input logic wr);
        ifb.valid_i          = 1'b1;
        ifb.funct3_i         = f3;
        ifb.op1_data_i       = a;
        ifb.op2_data_i       = b;
        ifb.rd_i             = rd;
        ifb.ctrl_reg_write_i = wr;
    endtask

    task automatic idle();
        ifa.valid_i = 1'b0;
        ifa.flush_i = 1'b0;
        ifb.valid_i = 1'b0;
        ifb.flush_i = 1'b0;
    endtask

    task automatic chk_res_a(input string tag, input logic [31:0] res, input logic [4:0] rd,
                             input logic wr);
        chk({tag, "_valid"}, 64'(ifa.valid_result_o), 64'd1);
        chk({tag, "_result"}, 64'(ifa.result_o), 64'(res));
        chk({tag, "_rd"}, 64'(ifa.rd_o), 64'(rd));
        chk({tag, "_wr"}, 64'(ifa.ctrl_reg_write_o), 64'(wr));
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_valid"}, 64'(ifa.valid_result_o), 64'd0);
        chk({tag, "_result"}, 64'(ifa.result_o), 64'd0);
        chk({tag, "_rd"}, 64'(ifa.rd_o), 64'd0);
        chk({tag, "_wr"}, 64'(ifa.ctrl_reg_write_o), 64'd0);
        chk({tag, "_ending"}, 64'(ifa.op_ending_o), 64'd0);
        chk({tag, "_busy"}, 64'(ifa.busy_o), 64'd0);
        chk({tag, "_unsup"}, 64'(ifa.unsupported_o), 64'd0);
    endtask

    initial begin
        ifa.valid_i = 1'b0; ifa.funct3_i = 3'd0; ifa.op1_data_i = '0; ifa.op2_data_i = '0;
        ifa.rd_i = '0; ifa.ctrl_reg_write_i = 1'b0; ifa.flush_i = 1'b0;
        ifb.valid_i = 1'b0; ifb.funct3_i = 3'd0; ifb.op1_data_i = '0; ifb.op2_data_i = '0;
        ifb.rd_i = '0; ifb.ctrl_reg_write_i = 1'b0; ifb.flush_i = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        tick();
        tick();
        chk_zero_a("reset");
        chk("reset_b_valid", 64'(ifb.valid_result_o), 64'd0);
        chk("reset_b_result", ifb.result_o, 64'd0);
        #2 reset_n = 1'b1;
        tick();

        // MUL 7 * -3 = -21
        issue_a(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b1);
        tick();
        idle();
        chk("mul_busy", 64'(ifa.busy_o), 64'd1);
        tick(); tick();
        chk("mul_early_ending", 64'(ifa.op_ending_o), 64'd0);
        tick();
        chk("mul_ending", 64'(ifa.op_ending_o), 64'd1);
        chk("mul_not_yet", 64'(ifa.valid_result_o), 64'd0);
        tick();
        chk_res_a("mul", 32'hFFFF_FFEB, 5'd3, 1'b1);
        chk("mul_ending_after", 64'(ifa.op_ending_o), 64'd0);
        tick();
        chk("mul_one_cycle", 64'(ifa.valid_result_o), 64'd0);
        chk("mul_idle_busy", 64'(ifa.busy_o), 64'd0);

        // Back-to-back sign modes
        issue_a(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5, 1'b1);
        tick();
        issue_a(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
        tick();
        issue_a(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);
        tick();
        idle();
        tick(); tick();
        chk_res_a("mulh", 32'h4000_0000, 5'd5, 1'b1);
        tick();
        chk_res_a("mulhu", 32'hFFFF_FFFE, 5'd6, 1'b1);
        tick();
        chk_res_a("mulhsu", 32'hFFFF_FFFF, 5'd7, 1'b1);
        tick();
        chk("b2b_done", 64'(ifa.valid_result_o), 64'd0);

        // Flush on cycle 2 kills cycles 0-2; the cycle-3 op completes five cycles later
        issue_a(3'b000, 32'd11, 32'd2, 5'd1, 1'b1);
        tick();
        issue_a(3'b000, 32'd13, 32'd2, 5'd2, 1'b1);
        tick();
        issue_a(3'b000, 32'd17, 32'd2, 5'd4, 1'b1);
        ifa.flush_i = 1'b1;
        chk("flush_ending_masked", 64'(ifa.op_ending_o), 64'd0);
        tick();
        ifa.flush_i = 1'b0;
        chk("flush_busy", 64'(ifa.busy_o), 64'd0);
        issue_a(3'b000, 32'd3, 32'd4, 5'd9, 1'b0);
        tick();
        idle();
        for (int i = 1; i < 5; i++) begin
            chk($sformatf("flush_quiet%0d", i), 64'(ifa.valid_result_o), 64'd0);
            tick();
        end
        chk_res_a("flush_survivor", 32'd12, 5'd9, 1'b0);
        tick();

        // Asynchronous reset with three ops in flight
        issue_a(3'b000, 32'd5, 32'd5, 5'd10, 1'b1);
        tick();
        issue_a(3'b001, 32'd6, 32'd6, 5'd11, 1'b1);
        tick();
        issue_a(3'b011, 32'd7, 32'd7, 5'd12, 1'b1);
        tick();
        idle();
        chk("rst_busy_before", 64'(ifa.busy_o), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_zero_a("rst_mid");
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("rst_stale%0d", i), 64'(ifa.valid_result_o), 64'd0);
        end

        // Division encoding is rejected with a one-cycle pulse
        issue_a(3'b100, 32'd100, 32'd7, 5'd8, 1'b1);
        tick();
        idle();
        chk("unsup_pulse", 64'(ifa.unsupported_o), 64'd1);
        chk("unsup_busy", 64'(ifa.busy_o), 64'd0);
        tick();
        chk("unsup_clear", 64'(ifa.unsupported_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("unsup_noresult%0d", i), 64'(ifa.valid_result_o), 64'd0);
        end

        // 64-bit, 2-stage instance
        issue_b(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 1'b1);
        tick();
        issue_b(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b1);
        chk("b_ending", 64'(ifb.op_ending_o), 64'd1);
        chk("b_not_yet", 64'(ifb.valid_result_o), 64'd0);
        tick();
        idle();
        chk("b_mul_valid", 64'(ifb.valid_result_o), 64'd1);
        chk("b_mul_result", ifb.result_o, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("b_mul_rd", 64'(ifb.rd_o), 64'd3);
        tick();
        chk("b_mulhu_valid", 64'(ifb.valid_result_o), 64'd1);
        chk("b_mulhu_result", ifb.result_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("b_mulhu_rd", 64'(ifb.rd_o), 64'd4);
        tick();
        chk("b_done", 64'(ifb.valid_result_o), 64'd0);
        chk("b_idle_busy", 64'(ifb.busy_o), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
